// File: rtl/fuel_pump_guard_pkg.sv
// fuel_pump_pkg: state encodings and shared widths for the fuel pump guard.
package fuel_pump_pkg;
    localparam int FAIL_W = 4;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMING  = 2'd1,
        ST_ON      = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;
endpackage

// File: rtl/fuel_pump_guard_if.sv
// fuel_pump_guard_if: driver inputs and guard status outputs.
interface fuel_pump_guard_if;
    import fuel_pump_pkg::*;

    logic              i_ignition;
    logic              i_switch;
    logic              i_pedal;
    logic              o_status;
    logic              o_armed;
    logic              o_locked;
    logic [FAIL_W-1:0] o_fail_count;
    logic [1:0]        o_state;

    modport master (
        output i_ignition, i_switch, i_pedal,
        input  o_status, o_armed, o_locked, o_fail_count, o_state
    );

    modport slave (
        input  i_ignition, i_switch, i_pedal,
        output o_status, o_armed, o_locked, o_fail_count, o_state
    );
endinterface

// File: rtl/fuel_pump_guard_hold_cnt.sv
// fuel_pump_hold_cnt: shared cycle counter for ARMING hold time and LOCKOUT duration.
// Stops at the terminal value so it can never wrap.
module fuel_pump_hold_cnt
    import fuel_pump_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_tc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == i_term);
endmodule

// File: rtl/fuel_pump_guard.sv
// fuel_pump_guard: anti-theft fuel pump interlock (OFF/ARMING/ON/LOCKOUT).
// Define FUEL_PUMP_LOCKOUT_EN to build the LOCKOUT state; otherwise failures only count.
module fuel_pump_guard
    import fuel_pump_pkg::*;
#(
    parameter int HOLD_CYCLES    = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fuel_pump_guard_if.slave   bus
);
    localparam int MAX_CYC = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]  HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [FAIL_W-1:0] MAX_F     = FAIL_W'(MAX_TRIES);
`ifdef FUEL_PUMP_LOCKOUT_EN
    localparam logic [CNT_W-1:0]  LOCK_TERM = CNT_W'(LOCKOUT_CYCLES - 1);
`endif

    state_t            r_state;
    logic [FAIL_W-1:0] r_fail;

    state_t            w_state_nxt;
    logic [FAIL_W-1:0] w_fail_nxt;
    logic [FAIL_W-1:0] w_fail_inc;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic [CNT_W-1:0]  w_term;
    logic              w_tc;
    logic              w_all;

    assign w_all      = bus.i_ignition & bus.i_switch & bus.i_pedal;
    assign w_fail_inc = (r_fail >= MAX_F) ? MAX_F : r_fail + 1'b1;

    fuel_pump_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_term  (w_term),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_OFF;
            r_fail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_term      = HOLD_TERM;
        case (r_state)
            ST_OFF: begin
                if (w_all) begin
                    w_state_nxt = ST_ARMING;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_ARMING: begin
                // Ignition loss is an abort, checked before any failure condition.
                if (!bus.i_ignition) begin
                    w_state_nxt = ST_OFF;
                end else if (bus.i_switch && bus.i_pedal) begin
                    if (w_tc) begin
                        w_state_nxt = ST_ON;
                        w_fail_nxt  = '0;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end else begin
                    w_fail_nxt = w_fail_inc;
`ifdef FUEL_PUMP_LOCKOUT_EN
                    if (w_fail_inc == MAX_F) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = ST_OFF;
                    end
`else
                    w_state_nxt = ST_OFF;
`endif
                end
            end
            ST_ON: begin
                w_fail_nxt = '0;
                if (!bus.i_ignition)
                    w_state_nxt = ST_OFF;
            end
            ST_LOCKOUT: begin
`ifdef FUEL_PUMP_LOCKOUT_EN
                w_term = LOCK_TERM;
                if (w_tc) begin
                    w_state_nxt = ST_OFF;
                    w_fail_nxt  = '0;
                end else begin
                    w_cnt_en = 1'b1;
                end
`else
                w_state_nxt = ST_OFF;
`endif
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    assign bus.o_state      = r_state;
    assign bus.o_fail_count = r_fail;
    assign bus.o_status     = (r_state == ST_ON);
    assign bus.o_armed      = (r_state == ST_ARMING);
`ifdef FUEL_PUMP_LOCKOUT_EN
    assign bus.o_locked     = (r_state == ST_LOCKOUT);
`else
    assign bus.o_locked     = 1'b0;
`endif
endmodule

// File: tb/tb_fuel_pump_guard.sv
// tb_fuel_pump_guard: scoreboard bench for fuel_pump_guard (HOLD=4, TRIES=3, LOCKOUT=8).
// Lockout scenarios are selected when FUEL_PUMP_LOCKOUT_EN is defined, saturation otherwise.
module tb_fuel_pump_guard;
    localparam int HOLD = 4;
    localparam int TRIES = 3;
    localparam int LOCK = 8;

    typedef struct packed {
        logic       ign;
        logic       sw;
        logic       pd;
        logic [1:0] st;
        logic [3:0] fc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [8:0] sb[$];

    fuel_pump_guard_if bus();

    fuel_pump_guard #(
        .HOLD_CYCLES    (HOLD),
        .MAX_TRIES      (TRIES),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic vec_t mk(logic ign, logic sw, logic pd, logic [1:0] st, logic [3:0] fc);
        vec_t v;
        v.ign = ign; v.sw = sw; v.pd = pd; v.st = st; v.fc = fc;
        return v;
    endfunction

    // {state, fail_count, status, armed, locked} implied by an expected state/count pair
    function automatic logic [8:0] exp_of(vec_t v);
        return {v.st, v.fc, v.st == 2'd2, v.st == 2'd1, v.st == 2'd3};
    endfunction

    function automatic logic [8:0] observed();
        return {bus.o_state, bus.o_fail_count, bus.o_status, bus.o_armed, bus.o_locked};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_ignition = 1'b0; bus.i_switch = 1'b0; bus.i_pedal = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        rst_n = 1'b0;
        bus.i_ignition = 1'b1; bus.i_switch = 1'b1; bus.i_pedal = 1'b1;
        #3;
        got = observed();
        n_cmp++;
        if (got !== 9'b0) begin
            n_err++;
            $display("FAIL reset_state: got %b required %b", got, 9'b0);
        end
        bus.i_ignition = 1'b0; bus.i_switch = 1'b0; bus.i_pedal = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arm_on();
        vec_t vq[$];
        logic [8:0] got, exp;
        for (int i = 0; i < HOLD; i++) vq.push_back(mk(1, 1, 1, 2'd1, 4'd0));
        vq.push_back(mk(1, 1, 1, 2'd2, 4'd0));
        vq.push_back(mk(1, 1, 1, 2'd2, 4'd0));
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL arm_on[%0d]: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_on_exit();
        vec_t vq[$];
        logic [8:0] got, exp;
        vq.push_back(mk(1, 0, 1, 2'd2, 4'd0));
        vq.push_back(mk(1, 1, 0, 2'd2, 4'd0));
        vq.push_back(mk(1, 0, 0, 2'd2, 4'd0));
        vq.push_back(mk(0, 1, 1, 2'd0, 4'd0));
        vq.push_back(mk(0, 1, 1, 2'd0, 4'd0));
        vq.push_back(mk(0, 0, 0, 2'd0, 4'd0));
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL on_exit[%0d]: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        vec_t vq[$];
        logic [8:0] got, exp;
        do_reset();
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd0));
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd0));
        vq.push_back(mk(1, 1, 0, 2'd0, 4'd1));
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd1));
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd1));
        vq.push_back(mk(0, 1, 1, 2'd0, 4'd1));
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd1));
        vq.push_back(mk(0, 1, 0, 2'd0, 4'd1));
        vq.push_back(mk(1, 0, 1, 2'd0, 4'd1));
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL abort[%0d]: got %b required %b", i, got, exp);
            end
        end
    endtask

`ifdef FUEL_PUMP_LOCKOUT_EN
    task automatic test_lockout();
        vec_t vq[$];
        logic [8:0] got, exp;
        do_reset();
        for (int t = 0; t < TRIES; t++) begin
            vq.push_back(mk(1, 1, 1, 2'd1, 4'(t)));
            vq.push_back(mk(1, 1, 1, 2'd1, 4'(t)));
            vq.push_back(mk(1, 1, 0, (t == TRIES - 1) ? 2'd3 : 2'd0, 4'(t + 1)));
        end
        for (int c = 1; c < LOCK; c++) vq.push_back(mk(1, 1, 1, 2'd3, 4'd3));
        vq.push_back(mk(1, 1, 1, 2'd0, 4'd0));
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd0));
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL lockout[%0d]: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        vec_t vq[$];
        logic [8:0] got, exp;
        do_reset();
        for (int t = 0; t < TRIES; t++) begin
            vq.push_back(mk(1, 1, 1, 2'd1, 4'(t)));
            vq.push_back(mk(1, 1, 1, 2'd1, 4'(t)));
            vq.push_back(mk(1, 1, 0, (t == TRIES - 1) ? 2'd3 : 2'd0, 4'(t + 1)));
        end
        vq.push_back(mk(1, 1, 1, 2'd3, 4'd3));
        vq.push_back(mk(1, 1, 1, 2'd3, 4'd3));
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL async_reset_pre[%0d]: got %b required %b", i, got, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1 got = observed();
        n_cmp++;
        if (got !== 9'b0) begin
            n_err++;
            $display("FAIL async_reset_lockout: got %b required %b", got, 9'b0);
        end
        #1 rst_n = 1'b1;
        bus.i_ignition = 1'b1; bus.i_switch = 1'b1; bus.i_pedal = 1'b1;
        sb.push_back(exp_of(mk(1, 1, 1, 2'd1, 4'd0)));
        @(posedge clk); #1;
        got = observed();
        exp = sb.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL async_reset_post: got %b required %b", got, exp);
        end
    endtask
`else
    task automatic test_saturate();
        vec_t vq[$];
        logic [8:0] got, exp;
        int f;
        do_reset();
        f = 0;
        for (int t = 0; t < 5; t++) begin
            vq.push_back(mk(1, 1, 1, 2'd1, 4'(f)));
            f = (f + 1 > TRIES) ? TRIES : f + 1;
            vq.push_back(mk(1, 1, 0, 2'd0, 4'(f)));
        end
        for (int i = 0; i < HOLD; i++) vq.push_back(mk(1, 1, 1, 2'd1, 4'd3));
        vq.push_back(mk(1, 1, 1, 2'd2, 4'd0));
        vq.push_back(mk(0, 0, 0, 2'd0, 4'd0));
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL saturate[%0d]: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        vec_t vq[$];
        logic [8:0] got, exp;
        do_reset();
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd0));
        vq.push_back(mk(1, 0, 1, 2'd0, 4'd1));
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd1));
        vq.push_back(mk(1, 1, 1, 2'd1, 4'd1));
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL async_reset_pre[%0d]: got %b required %b", i, got, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1 got = observed();
        n_cmp++;
        if (got !== 9'b0) begin
            n_err++;
            $display("FAIL async_reset_arming: got %b required %b", got, 9'b0);
        end
        #1 rst_n = 1'b1;
        sb.push_back(exp_of(mk(1, 1, 1, 2'd1, 4'd0)));
        @(posedge clk); #1;
        got = observed();
        exp = sb.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL async_reset_post: got %b required %b", got, exp);
        end
    endtask
`endif

    task automatic test_back_to_back();
        vec_t vq[$];
        logic [8:0] got, exp;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < HOLD; i++) vq.push_back(mk(1, 1, 1, 2'd1, 4'd0));
            vq.push_back(mk(1, 1, 1, 2'd2, 4'd0));
            vq.push_back(mk(0, 1, 1, 2'd0, 4'd0));
        end
        foreach (vq[i]) begin
            bus.i_ignition = vq[i].ign; bus.i_switch = vq[i].sw; bus.i_pedal = vq[i].pd;
            sb.push_back(exp_of(vq[i]));
            @(posedge clk); #1;
            got = observed();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b required %b", i, got, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_ignition = 1'b0; bus.i_switch = 1'b0; bus.i_pedal = 1'b0;
        test_reset();
        test_arm_on();
        test_on_exit();
        test_abort();
`ifdef FUEL_PUMP_LOCKOUT_EN
        test_lockout();
`else
        test_saturate();
`endif
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
